// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch unit with in-order memory fetch and a DEPTH-entry queue
module fetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_tvalid,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             out_tvalid,
    output logic [WIDTH-1:0] out_tdata,
    input  logic             out_tready,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    assign push       = in_tvalid && !flush;
    assign pop        = out_tvalid && out_tready && !flush;
    assign out_tvalid = (count != '0);
    assign out_tdata  = store[head];

    // Flush only rewinds pointers; storage is zeroed on reset alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                store[tail] <= in_tdata;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [31:0]      redirect_base;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_left;
    logic [CNT_W-1:0] drop;
    logic [CNT_W:0]   credit_used;
    logic             grant;
    logic             retire;
    logic             keep;
    logic [63:0]      head_data;

    // Queued plus in-flight instructions never exceed DEPTH, so a kept
    // response always finds a free slot.
    assign credit_used      = {1'b0, count} + {1'b0, outstanding};
    assign mem_req          = !reset && !redirect && (credit_used < (CNT_W + 1)'(DEPTH));
    assign mem_addr         = fetch_pc;
    assign grant            = mem_req && mem_gnt;
    assign retire           = mem_rvalid && (outstanding != '0);
    assign outstanding_left = outstanding - CNT_W'(retire);
    assign keep             = mem_rvalid && (drop == '0) && !redirect;
    assign redirect_base    = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_base;
            resp_pc     <= redirect_base;
            outstanding <= outstanding_left;
            drop        <= outstanding_left;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (keep) begin
                resp_pc <= resp_pc + 32'd4;
            end
            outstanding <= outstanding_left + CNT_W'(grant);
            if (mem_rvalid && (drop != '0)) begin
                drop <= drop - 1'b1;
            end
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .in_tvalid  (keep),
        .in_tdata   ({resp_pc, mem_rdata}),
        .out_tvalid (out_valid),
        .out_tdata  (head_data),
        .out_tready (out_ready),
        .count      (count)
    );

    assign out_pc   = head_data[63:32];
    assign out_inst = head_data[31:0];
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized check of fetch_queue against a transaction-level queue model
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0040;
    localparam int          N_CYC    = 4000;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; logic stale; } pend_t;
    typedef struct { logic [31:0] addr; int ready; } mresp_t;

    ent_t        m_fifo [$];
    pend_t       m_pend [$];
    mresp_t      mem_q  [$];
    logic [31:0] m_fetch;
    bit          m_fresh;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_pend.delete();
        m_fetch = RESET_PC;
        m_fresh = 1'b1;
    endtask

    initial begin
        int          mode;
        bit          m_req;
        bit          dut_grant;
        logic [31:0] dut_addr;
        bit          have_push;
        ent_t        pe;
        pend_t       e;

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        model_reset();

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clock);
            mode        = (cyc / 256) % 3;
            reset       = (cyc < 2) || ($urandom_range(0, 299) == 0);
            redirect    = !reset && ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFFC;
                1:       redirect_pc = 32'h0000_1003;
                default: redirect_pc = $urandom();
            endcase
            out_ready   = (mode == 0) ? 1'b1 :
                          (mode == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            mem_gnt     = (mode == 0) || ($urandom_range(0, 3) != 0);
            mem_rvalid  = !reset && (mem_q.size() > 0) && (mem_q[0].ready <= cyc) &&
                          ((mode == 0) || ($urandom_range(0, 3) != 0));
            mem_rdata   = mem_rvalid ? inst_of(mem_q[0].addr) : $urandom();
            #1;
            m_req = !reset && !redirect && ((m_fifo.size() + m_pend.size()) < DEPTH);
            check_eq("mem_req", mem_req, m_req);
            if (m_req) check_eq("mem_addr", mem_addr, m_fetch);
            if (cyc > 0) begin
                check_eq("out_valid", out_valid, m_fifo.size() != 0);
                if (m_fifo.size() != 0) begin
                    check_eq("out_pc", out_pc, m_fifo[0].pc);
                    check_eq("out_inst", out_inst, m_fifo[0].inst);
                end else if (m_fresh) begin
                    check_eq("rst_out_pc", out_pc, 32'h0);
                    check_eq("rst_out_inst", out_inst, 32'h0);
                end
                if (!reset) check_eq("push_full", mem_rvalid && !redirect && (dut.count == DEPTH), 1'b0);
            end
            dut_grant = mem_req && mem_gnt;
            dut_addr  = mem_addr;

            @(posedge clock);
            if (reset) begin
                mem_q.delete();
            end else begin
                if (mem_rvalid) void'(mem_q.pop_front());
                if (dut_grant) mem_q.push_back('{addr: dut_addr, ready: cyc + 1 + int'($urandom_range(0, 2))});
            end

            if (reset) begin
                model_reset();
            end else begin
                have_push = 1'b0;
                if (mem_rvalid && (m_pend.size() != 0)) begin
                    e = m_pend.pop_front();
                    if (!e.stale && !redirect) begin
                        have_push = 1'b1;
                        pe = '{pc: e.addr, inst: inst_of(e.addr)};
                    end
                end
                if (redirect) begin
                    m_fifo.delete();
                    foreach (m_pend[i]) m_pend[i].stale = 1'b1;
                    m_fetch = redirect_pc & ~32'h3;
                end else begin
                    if ((m_fifo.size() != 0) && out_ready) void'(m_fifo.pop_front());
                    if (m_req && mem_gnt) begin
                        m_pend.push_back('{addr: m_fetch, stale: 1'b0});
                        m_fetch = m_fetch + 32'd4;
                    end
                    if (have_push) begin
                        m_fifo.push_back(pe);
                        m_fresh = 1'b0;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch unit with a prefetch queue, sitting directly upstream of the CPU's register-read/decode stage. It issues in-order word requests to instruction memory over a request/grant and response-valid handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It hands them to the pipeline under a valid/ready handshake. On a redirect (branch, jal, jalr), it flushes the queue, discards in-flight responses and refetches from the new PC.

## Interface
- DEPTH, 4, queue entries and maximum outstanding-plus-buffered instructions; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0
- mem_req  out  1  instruction memory request
- mem_addr  out  32  word-aligned request address
- mem_gnt  in  1  request accepted this cycle (only meaningful with mem_req)
- mem_rvalid  in  1  response data valid; responses return in request order, ≥ 1 cycle after grant
- mem_rdata  in  32  response instruction word
- out_valid  out  1  head entry valid
- out_pc  out  32  PC of head instruction
- out_inst  out  32  head instruction word
- out_ready  in  1  consumer accepts head this cycle

## Operation
- State: fetch_pc (next request address), resp_pc (PC of next kept response), FIFO (DEPTH × {pc, inst}, head/tail pointers, count 0..DEPTH), outstanding (granted, not yet returned, 0..DEPTH), drop (responses to discard, ≤ outstanding).
- mem_req = !reset && !redirect && (count + outstanding < DEPTH). mem_addr = fetch_pc.
- Grant (mem_req && mem_gnt): fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
- Response (mem_rvalid): outstanding -= 1. If drop > 0 or redirect is high this cycle: discard, and drop -= 1 if drop > 0. Otherwise push {resp_pc, mem_rdata} and resp_pc += 4.
- Pop: out_valid && out_ready && !redirect advances head and decrements count.
- Push and pop in the same cycle: count is unchanged. Overflow is impossible by the credit rule. A push while mem_rvalid arrives with count = DEPTH is a protocol violation, flagged by a bench assertion.
- Redirect, registered:
  - count ← 0 and pointers reset.
  - fetch_pc and resp_pc ← {redirect_pc[31:2], 2'b00}.
  - drop ← outstanding after this cycle's response is accounted.
  - No request is issued in the redirect cycle.
  - Redirect takes priority over a simultaneous pop, push or response.
- out_valid = (count != 0). out_pc and out_inst are driven combinationally from the head entry.
- Reset:
  - fetch_pc = resp_pc = RESET_PC; count = outstanding = drop = 0.
  - FIFO storage is cleared to 0, so out_valid = 0, out_pc = 0, out_inst = 0.
  - mem_req = 0 while reset is high.
  - Reset mid-transaction abandons outstanding responses. The memory must be reset in the same cycle.

## Timing
- First mem_req in the cycle after reset deasserts, with mem_addr = RESET_PC.
- Latency from mem_rvalid to out_valid is 1 cycle; push is registered.
- Redirect at cycle N: out_valid = 0 at N+1; mem_req with mem_addr = redirect_pc at N+1 if credit is available.
- mem_addr is held stable while mem_req is high and not granted. mem_req may be withdrawn only on redirect or reset.
- Sustained throughput is 1 instruction/cycle when the grant→rvalid latency L ≤ DEPTH−1 and out_ready is held high.

## Test plan
- Reset, then mem_gnt = 1 always, responses 1 cycle after grant with data = address, out_ready = 1 → out_pc/out_inst = 0,4,8,… on consecutive cycles; first out_valid 3 cycles after reset deasserts.
- out_ready = 0 with immediate grants → exactly 4 grants (addresses 0..C), mem_req then low, count = 4. Raise out_ready → one pop per cycle, and each pop re-enables one request.
- 3 outstanding requests, then redirect with redirect_pc = 0x1003 → next mem_addr = 0x1000. The 3 stale responses are dropped; first out_pc = 0x1000.
- Redirect in the same cycle as a mem_rvalid and a pop → that response is dropped, queue is empty next cycle, drop equals remaining outstanding.
- Redirect to 0xFFFF_FFFC → addresses 0xFFFF_FFFC then 0x0000_0000; out_pc wraps identically.
- Assert reset mid-stream with count = 2 and outstanding = 2 → next cycle out_valid = 0, out_pc = 0, mem_req = 0. After deassert, fetch restarts at RESET_PC.
